// File: rtl/ysyx_24100006_pkg.sv
// ysyx_24100006_pkg: shared fetch state, error codes and bus/instruction constants
package ysyx_24100006_pkg;
  typedef enum logic [1:0] {S_REQ, S_RESP, S_OUT, S_WAITPC} ifu_state_e;
  localparam logic [1:0] IFU_ERR_NONE     = 2'd0;
  localparam logic [1:0] IFU_ERR_MISALIGN = 2'd1;
  localparam logic [1:0] IFU_ERR_ACCESS   = 2'd2;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [31:0] NOP_INST        = 32'h0000_0013;
endpackage

// File: rtl/ysyx_24100006_ifu_perf.sv
// ysyx_24100006_ifu_perf: free-running fetch and stall event counters (YSYX_24100006_IFU_PERF_EN)
module ysyx_24100006_ifu_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch,
  input  logic        stall,
  output logic [63:0] fetch_cnt,
  output logic [63:0] stall_cnt
);
  // count delivered instructions and cycles spent waiting on memory; both wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + {63'd0, fetch};
      stall_cnt <= stall_cnt + {63'd0, stall};
    end
  end
endmodule

// File: rtl/ysyx_24100006_ifu_fetch.sv
// ysyx_24100006_ifu_fetch: PC holder and single-outstanding instruction fetch initiator; optional counters under YSYX_24100006_IFU_PERF_EN
module ysyx_24100006_ifu_fetch
  import ysyx_24100006_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            next_pc_valid,
  input  logic [XLEN-1:0] next_pc,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_pc,
  output logic            arvalid,
  output logic [XLEN-1:0] araddr,
  input  logic            arready,
  input  logic            rvalid,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  output logic            rready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [1:0]      out_err
`ifdef YSYX_24100006_IFU_PERF_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt
`endif
);
  ifu_state_e state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic drop, drop_n;
  logic ar_fire, misalign, err_load, take, resp_ok;
  assign ar_fire  = arvalid & arready;
  assign misalign = pc[1:0] != 2'b00;
  assign araddr   = pc;
  assign err_load = state == S_REQ && !flush_valid && misalign;
  assign take     = state == S_RESP && rvalid && !drop && !flush_valid;
  assign resp_ok  = rresp == RESP_OKAY;
  // next state, PC and discard flag; a flush always retargets the PC and outranks everything
  always_comb begin
    state_n = state;
    pc_n    = flush_valid ? flush_pc : pc;
    drop_n  = drop;
    case (state)
      S_REQ: begin
        if (ar_fire) begin
          state_n = S_RESP;
          drop_n  = flush_valid;
        end else if (!flush_valid && misalign) begin
          state_n = S_OUT;
        end
      end
      S_RESP: begin
        if (rvalid) begin
          state_n = (drop || flush_valid) ? S_REQ : S_OUT;
          drop_n  = 1'b0;
        end else if (flush_valid) begin
          drop_n  = 1'b1;
        end
      end
      S_OUT: state_n = flush_valid ? S_REQ : out_ready ? S_WAITPC : S_OUT;
      S_WAITPC: begin
        if (!flush_valid && next_pc_valid) pc_n = next_pc;
        state_n = (flush_valid || next_pc_valid) ? S_REQ : S_WAITPC;
      end
      default: state_n = S_REQ;
    endcase
  end
  // state and registered handshake/payload outputs; the address is only offered when aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= RESET_PC;
      out_inst  <= '0;
      out_err   <= IFU_ERR_NONE;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drop      <= drop_n;
      arvalid   <= state_n == S_REQ && pc_n[1:0] == 2'b00;
      rready    <= state_n == S_RESP;
      out_valid <= state_n == S_OUT;
      if (err_load) begin
        out_pc   <= pc;
        out_inst <= XLEN'(NOP_INST);
        out_err  <= IFU_ERR_MISALIGN;
      end else if (take) begin
        out_pc   <= pc;
        out_inst <= resp_ok ? rdata : XLEN'(NOP_INST);
        out_err  <= resp_ok ? IFU_ERR_NONE : IFU_ERR_ACCESS;
      end
    end
  end
`ifdef YSYX_24100006_IFU_PERF_EN
  ysyx_24100006_ifu_perf u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch     (out_valid & out_ready),
    .stall     (state == S_REQ || state == S_RESP),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif
endmodule
